// File: rtl/sha_pad.sv
// sha_pad: packs a big-endian byte message into FIPS 180-4 padded 512-bit blocks for SHA-224/256.
// Latency: last word accepted -> blk_enable two cycles later; 16th word of a full block -> blk_enable next cycle.
// Backpressure: in_ready is low from block hand-off until blk_done (WAIT_DONE=1) or for PAD/SEND only (WAIT_DONE=0).
module sha_pad #(
    parameter bit WAIT_DONE = 1'b1,
    parameter int LEN_W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    input  logic         in_op,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic [63:0]  blk_index,
    output logic         blk_op,
    output logic         blk_enable,
    input  logic         blk_done,
    output logic         msg_done
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, SEND, WAIT} state_t;

    localparam logic [31:0] MARKER = 32'h8000_0000;

    state_t           state;
    logic [511:0]     buf_q;      // block under construction, word w at [32*w +: 32]
    logic [4:0]       wp;         // next word slot, 0..16
    logic [4:0]       mark_idx;   // slot holding the 0x80 marker; 16 means it spills into the next block
    logic [LEN_W-1:0] len_q;      // message length in bits
    logic             pend_len;   // a length-only follow-up block is still owed
    logic             pend_mark;  // that follow-up block also carries the marker in word 0
    logic             final_q;    // block currently handed off is the last of the message

    logic             accept;
    logic             advance;
    logic [2:0]       nb;
    logic [31:0]      wdat;
    logic [63:0]      len64;
    logic [511:0]     acc_blk;
    logic [511:0]     pad_blk;

    assign accept  = in_valid & in_ready;
    assign advance = (state == SEND && !WAIT_DONE) || (state == WAIT && blk_done);

    // Byte count of the incoming word and the word as stored, with marker and masking applied
    always_comb begin
        nb = (in_last && in_bytes < 3'd4) ? in_bytes : 3'd4;
        case (nb)
            3'd0:    wdat = MARKER;
            3'd1:    wdat = {in_data[31:24], 24'h80_0000};
            3'd2:    wdat = {in_data[31:16], 16'h8000};
            3'd3:    wdat = {in_data[31:8], 8'h80};
            default: wdat = in_data;
        endcase
        len64 = '0;
        len64[LEN_W-1:0] = len_q;
    end

    // Buffer contents after the accepted word (plus a trailing marker word for a full last word)
    always_comb begin
        acc_blk = buf_q;
        for (int w = 0; w < 16; w++) begin
            if (5'(w) == wp)
                acc_blk[32*w +: 32] = wdat;
            else if (in_last && nb == 3'd4 && 5'(w) == wp + 5'd1)
                acc_blk[32*w +: 32] = MARKER;
        end
    end

    // Padded block: zero past the marker, length in words 14/15 when it fits or on the follow-up block
    always_comb begin
        pad_blk = '0;
        for (int w = 0; w < 16; w++) begin
            if (pend_len) begin
                if (w == 0 && pend_mark)
                    pad_blk[31:0] = MARKER;
            end else if (5'(w) <= mark_idx) begin
                pad_blk[32*w +: 32] = buf_q[32*w +: 32];
            end
        end
        if (pend_len || mark_idx <= 5'd13) begin
            pad_blk[479:448] = len64[63:32];
            pad_blk[511:480] = len64[31:0];
        end
    end

    // Message/block sequencing with registered handshake and block outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            blk_enable <= 1'b0;
            msg_done   <= 1'b0;
            blk_data   <= '0;
            blk_index  <= '0;
            blk_op     <= 1'b0;
            wp         <= '0;
            mark_idx   <= '0;
            len_q      <= '0;
            buf_q      <= '0;
            pend_len   <= 1'b0;
            pend_mark  <= 1'b0;
            final_q    <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        if (state == IDLE)
                            blk_op <= in_op;
                        buf_q <= acc_blk;
                        wp    <= wp + 5'd1;
                        len_q <= len_q + LEN_W'({nb, 3'b000});
                        if (in_last) begin
                            state    <= PAD;
                            in_ready <= 1'b0;
                            mark_idx <= (nb == 3'd4) ? wp + 5'd1 : wp;
                        end else if (wp == 5'd15) begin
                            state      <= SEND;
                            in_ready   <= 1'b0;
                            blk_data   <= acc_blk;
                            blk_enable <= 1'b1;
                            final_q    <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                PAD: begin
                    blk_data   <= pad_blk;
                    blk_enable <= 1'b1;
                    final_q    <= pend_len || (mark_idx <= 5'd13);
                    pend_len   <= !pend_len && (mark_idx > 5'd13);
                    pend_mark  <= !pend_len && (mark_idx == 5'd16);
                    state      <= SEND;
                end
                SEND, WAIT: begin
                    blk_enable <= 1'b0;
                    if (advance) begin
                        wp    <= '0;
                        buf_q <= '0;
                        if (pend_len) begin
                            blk_index <= blk_index + 64'd1;
                            state     <= PAD;
                            in_ready  <= 1'b0;
                        end else if (final_q) begin
                            blk_index <= '0;
                            len_q     <= '0;
                            msg_done  <= 1'b1;
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                        end else begin
                            blk_index <= blk_index + 64'd1;
                            state     <= FILL;
                            in_ready  <= 1'b1;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_pad.sv
// tb_sha_pad: drives byte messages into sha_pad and compares every block against
// a byte-level FIPS 180-4 padding model, plus handshake, latency and reset behaviour.
module tb_sha_pad;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         in_op;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] blk_data;
    logic [63:0]  blk_index;
    logic         blk_op;
    logic         blk_enable;
    logic         blk_done;
    logic         msg_done;

    int total = 0;
    int bad   = 0;
    bit abort = 1'b0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_q[$];
    logic [511:0] got_q[$];
    time          last_acc_t;

    always #5 clk = ~clk;

    sha_pad dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_bytes   (in_bytes),
        .in_last    (in_last),
        .in_op      (in_op),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .blk_data   (blk_data),
        .blk_index  (blk_index),
        .blk_op     (blk_op),
        .blk_enable (blk_enable),
        .blk_done   (blk_done),
        .msg_done   (msg_done)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},   512'(in_ready),   512'(1));
        check({tag, "_blk_enable"}, 512'(blk_enable), 512'(0));
        check({tag, "_msg_done"},   512'(msg_done),   512'(0));
        check({tag, "_blk_data"},   blk_data,         512'(0));
        check({tag, "_blk_index"},  512'(blk_index),  512'(0));
        check({tag, "_blk_op"},     512'(blk_op),     512'(0));
    endtask

    task automatic fill_rand(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    // Reference: append 0x80, zero to 56 mod 64, then 64-bit big-endian bit length
    task automatic build_exp();
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        p = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_q.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int w = 0; w < 16; w++)
                blk[32*w +: 32] = {p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]};
            exp_q.push_back(blk);
        end
    endtask

    // Drive msg_q as words (or only the first np words, never marked last, when partial)
    task automatic drive(input bit op, input bit partial, input int np);
        int n;
        int nw;
        int left;
        int t;
        logic [31:0] d;
        n  = msg_q.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        if (partial) nw = np;
        for (int i = 0; i < nw && !abort; i++) begin
            left = n - 4 * i;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            d = $urandom;
            for (int k = 0; k < 4; k++)
                if (k < left) d[31-8*k -: 8] = msg_q[4*i+k];
            in_data  = d;
            in_op    = (i == 0) ? op : 1'($urandom);
            in_last  = !partial && (i == nw - 1);
            in_bytes = in_last ? 3'(left) : 3'($urandom);
            in_valid = 1'b1;
            t = 0;
            while (in_ready !== 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            check("accept_wait", 512'(in_ready), 512'(1));
            if (in_ready !== 1'b1) abort = 1'b1;
            if (in_last) last_acc_t = $time;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Receive each block, compare it, hold blk_done off for dmin..dmax cycles
    task automatic collect(input bit op, input int dmin, input int dmax);
        int n;
        int nblk;
        int lastw_blk;
        int t;
        int dly;
        logic rdy_hi;
        n         = msg_q.size();
        nblk      = exp_q.size();
        lastw_blk = (((n == 0) ? 1 : (n + 3) / 4) - 1) / 16;
        for (int b = 0; b < nblk && !abort; b++) begin
            t = 0;
            while (blk_enable !== 1'b1 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            check("blk_enable_wait", 512'(blk_enable), 512'(1));
            if (blk_enable !== 1'b1) begin
                abort = 1'b1;
                return;
            end
            check($sformatf("blk%0d_data", b), blk_data, exp_q[b]);
            check($sformatf("blk%0d_index", b), 512'(blk_index), 512'(b));
            check("blk_op", 512'(blk_op), 512'(op));
            if (b == lastw_blk)
                check("last_word_latency", 512'($time - last_acc_t), 512'(20));
            got_q.push_back(blk_data);
            dly = $urandom_range(dmin, dmax);
            @(negedge clk);
            check("enable_one_cycle", 512'(blk_enable), 512'(0));
            rdy_hi = in_ready;
            for (int k = 1; k < dly; k++) begin
                @(negedge clk);
                rdy_hi = rdy_hi | in_ready;
            end
            check("ready_low_in_wait", 512'(rdy_hi), 512'(0));
            blk_done = 1'b1;
            @(negedge clk);
            blk_done = 1'b0;
            check("msg_done", 512'(msg_done), 512'(b == nblk - 1));
            if (b == nblk - 1) begin
                @(negedge clk);
                check("msg_done_pulse", 512'(msg_done), 512'(0));
            end
        end
    endtask

    task automatic run_msg(input bit op, input int dmin, input int dmax);
        build_exp();
        got_q.delete();
        fork
            drive(op, 1'b0, 0);
            collect(op, dmin, dmax);
        join
        check("block_count", 512'(got_q.size()), 512'(exp_q.size()));
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_bytes = '0;
        in_last  = 1'b0;
        in_op    = 1'b0;
        in_valid = 1'b0;
        blk_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // "abc"
        msg_q = {8'h61, 8'h62, 8'h63};
        run_msg(1'b1, 1, 3);
        if (got_q.size() > 0) begin
            check("abc_w0",  512'(got_q[0][31:0]),    512'(32'h6162_6380));
            check("abc_w15", 512'(got_q[0][511:480]), 512'(32'h0000_0018));
        end

        // empty message
        msg_q.delete();
        run_msg(1'b0, 1, 2);
        if (got_q.size() > 0)
            check("empty_w0", 512'(got_q[0][31:0]), 512'(32'h8000_0000));

        // 55 bytes: marker and length share one block
        fill_rand(55);
        run_msg(1'b1, 1, 4);
        if (got_q.size() > 0) begin
            check("b55_w13_lo", 512'(got_q[0][423:416]), 512'(8'h80));
            check("b55_w15",    512'(got_q[0][511:480]), 512'(32'h0000_01B8));
        end

        // 56 bytes: length spills into a second block
        fill_rand(56);
        run_msg(1'b0, 1, 4);
        if (got_q.size() == 2) begin
            check("b56_blk0_w14", 512'(got_q[0][479:448]), 512'(32'h8000_0000));
            check("b56_blk1_w15", 512'(got_q[1][511:480]), 512'(32'h0000_01C0));
        end

        // 64 bytes: marker starts the follow-up block
        fill_rand(64);
        run_msg(1'b1, 1, 3);

        // long core latency with input waiting behind a full block
        fill_rand(100);
        run_msg(1'b0, 70, 70);

        // random lengths around block boundaries
        for (int m = 0; m < 8 && !abort; m++) begin
            fill_rand($urandom_range(0, 150));
            run_msg(1'($urandom), 1, 4);
        end

        // reset in the middle of FILL, then a fresh message
        fill_rand(40);
        drive(1'b1, 1'b1, 5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #2;
        check_reset("midfill_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        msg_q = {8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
